// File: rtl/hc_deser_rx.sv
// Half-cycle serial receiver: LSB-first deserializer feeding a 2-entry valid/ready FIFO.
// Optional even-parity bit per word when HC_DESER_PARITY_EN is defined.
module hc_deser_rx #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rb,
    input  logic             sin,
    input  logic             sval,
    input  logic             ssof,
    output logic [WIDTH-1:0] dout,
    output logic             dvld,
    input  logic             drdy,
    output logic             perr,
    output logic             ovf,
    output logic             busy
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {StShift, StPar} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;

    logic             push;
    logic             push_perr;
    logic [WIDTH-1:0] push_word;
    logic             pop;

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic [1:0]       perr_q, perr_d;
    logic [1:0]       fcnt_q, fcnt_d;
    logic             ovf_q, ovf_d;

    // Deserializer: state only moves on edges where sval qualifies the bit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        push      = 1'b0;
        push_word = {sin, shreg_q[WIDTH-1:1]};
        push_perr = 1'b0;
        if (sval) begin
            if (ssof) begin
                state_d = StShift;
                cnt_d   = CW'(1);
                shreg_d = {sin, {(WIDTH-1){1'b0}}};
            end else begin
`ifdef HC_DESER_PARITY_EN
                if (state_q == StPar) begin
                    push      = 1'b1;
                    push_word = shreg_q;
                    push_perr = ^{shreg_q, sin};
                    state_d   = StShift;
                    cnt_d     = '0;
                end else
`endif
                begin
                    shreg_d = {sin, shreg_q[WIDTH-1:1]};
                    if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef HC_DESER_PARITY_EN
                        state_d = StPar;
                        cnt_d   = CW'(WIDTH);
`else
                        push  = 1'b1;
                        cnt_d = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
        end
    end

    // FIFO: entry 0 is the head; a pop frees a slot for a same-edge push when full.
    always_comb begin
        mem_d  = mem_q;
        perr_d = perr_q;
        fcnt_d = fcnt_q;
        ovf_d  = ovf_q;
        pop    = dvld && drdy;
        if (pop) begin
            mem_d[0]  = mem_q[1];
            perr_d[0] = perr_q[1];
            mem_d[1]  = '0;
            perr_d[1] = 1'b0;
            fcnt_d    = fcnt_q - 2'd1;
        end
        if (push) begin
            if (fcnt_d == 2'd2) begin
                ovf_d = 1'b1;
            end else begin
                mem_d[fcnt_d[0]]  = push_word;
                perr_d[fcnt_d[0]] = push_perr;
                fcnt_d            = fcnt_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rb) begin
        if (!rb) begin
            state_q <= StShift;
            cnt_q   <= '0;
            shreg_q <= '0;
            mem_q   <= '{default: '0};
            perr_q  <= '0;
            fcnt_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            mem_q   <= mem_d;
            perr_q  <= perr_d;
            fcnt_q  <= fcnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign dvld = (fcnt_q != 2'd0);
    assign dout = dvld ? mem_q[0] : '0;
    assign perr = dvld & perr_q[0];
    assign ovf  = ovf_q;
    assign busy = (cnt_q != '0) || (state_q == StPar);

endmodule

// File: tb/tb_hc_deser_rx.sv
// Self-checking bench for hc_deser_rx: directed scenarios plus randomized traffic
// compared against a word/queue-level reference model.
module tb_hc_deser_rx;
    localparam int unsigned W  = 8;
    localparam int unsigned OW = W + 4;

    logic         clk;
    logic         rb;
    logic         sin;
    logic         sval;
    logic         ssof;
    logic [W-1:0] dout;
    logic         dvld;
    logic         drdy;
    logic         perr;
    logic         ovf;
    logic         busy;

    int checks = 0;
    int errors = 0;

    hc_deser_rx #(.WIDTH(W)) dut (
        .clk  (clk),
        .rb   (rb),
        .sin  (sin),
        .sval (sval),
        .ssof (ssof),
        .dout (dout),
        .dvld (dvld),
        .drdy (drdy),
        .perr (perr),
        .ovf  (ovf),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: bit position counter, word assembled by index, queue FIFO.
    typedef struct packed {
        logic [W-1:0] d;
        logic         p;
    } ent_t;

    ent_t         q[$];
    int           m_cnt;
    logic [W-1:0] m_word;
    bit           m_inpar;
    bit           m_ovf;

    function automatic void model_clear();
        q.delete();
        m_cnt   = 0;
        m_word  = '0;
        m_inpar = 0;
        m_ovf   = 0;
    endfunction

    function automatic void model_step(input logic s, input logic v, input logic f,
                                       input logic r);
        bit   do_push;
        ent_t e;
        int   sz;
        bit   pp;
        do_push = 0;
        e       = '0;
        sz      = q.size();
        pp      = (sz > 0) && r;
        if (v) begin
            if (f) begin
                m_cnt   = 0;
                m_word  = '0;
                m_inpar = 0;
            end
            if (m_inpar) begin
                e.d     = m_word;
                e.p     = (^m_word) ^ s;
                do_push = 1;
                m_inpar = 0;
                m_cnt   = 0;
                m_word  = '0;
            end else begin
                m_word[m_cnt] = s;
                m_cnt++;
                if (m_cnt == W) begin
`ifdef HC_DESER_PARITY_EN
                    m_inpar = 1;
`else
                    e.d     = m_word;
                    do_push = 1;
                    m_cnt   = 0;
                    m_word  = '0;
`endif
                end
            end
        end
        if (pp) void'(q.pop_front());
        if (do_push) begin
            if (sz == 2 && !pp) m_ovf = 1;
            else q.push_back(e);
        end
    endfunction

    // Expected {dvld, dout, perr, ovf, busy}
    function automatic logic [OW-1:0] exp_outs();
        logic [W-1:0] d;
        logic         p;
        logic         b;
        d = '0;
        p = 1'b0;
        if (q.size() > 0) begin
            d = q[0].d;
            p = q[0].p;
        end
        b = (m_cnt != 0) || m_inpar;
        return {q.size() > 0, d, p, m_ovf, b};
    endfunction

    function automatic logic [OW-1:0] obs();
        return {dvld, dout, perr, ovf, busy};
    endfunction

    // One clock: inputs applied at the falling edge, model advanced at the rising edge.
    task automatic step(input logic s, input logic v, input logic f, input logic r);
        sin  = s;
        sval = v;
        ssof = f;
        drdy = r;
        @(posedge clk);
        model_step(s, v, f, r);
        @(negedge clk);
    endtask

    // Sends a word LSB-first (plus correct parity when enabled); r_last drives the final bit.
    task automatic send_word(input logic [W-1:0] w, input bit sof, input logic r_body,
                             input logic r_last);
        for (int i = 0; i < W; i++) begin
`ifdef HC_DESER_PARITY_EN
            step(w[i], 1'b1, sof && (i == 0), r_body);
`else
            step(w[i], 1'b1, sof && (i == 0), (i == W - 1) ? r_last : r_body);
`endif
        end
`ifdef HC_DESER_PARITY_EN
        step(^w, 1'b1, 1'b0, r_last);
`endif
    endtask

    task automatic apply_reset();
        rb   = 1'b0;
        sin  = 1'b0;
        sval = 1'b0;
        ssof = 1'b0;
        drdy = 1'b0;
        repeat (2) @(negedge clk);
        rb = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        rb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sin  = 1'($urandom);
            sval = 1'($urandom);
            ssof = 1'($urandom);
            drdy = 1'($urandom);
            @(negedge clk);
            checks++;
            if (obs() !== '0) begin
                errors++;
                $display("FAIL reset_hold got %h want %h", obs(), {OW{1'b0}});
            end
        end
        sval = 1'b0;
        ssof = 1'b0;
        rb   = 1'b1;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            step(1'($urandom), 1'b0, 1'($urandom), 1'($urandom));
            checks++;
            if (obs() !== '0 || obs() !== exp_outs()) begin
                errors++;
                $display("FAIL reset_release got %h want %h", obs(), {OW{1'b0}});
            end
        end
    endtask

    task automatic test_back_to_back();
        send_word(8'hA5, 1'b1, 1'b1, 1'b1);
        checks++;
        if (obs() !== {1'b1, 8'hA5, 1'b0, 1'b0, 1'b0} || obs() !== exp_outs()) begin
            errors++;
            $display("FAIL b2b_word got %h want %h", obs(), {1'b1, 8'hA5, 3'b000});
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (dvld !== 1'b0 || dout !== 8'h00) begin
            errors++;
            $display("FAIL b2b_one_cycle got dvld=%b dout=%h want dvld=0 dout=00", dvld, dout);
        end
    endtask

    task automatic test_gapped();
        logic [W-1:0] w;
        w = 8'h3C;
        for (int i = 0; i < W; i++) begin
            step(w[i], 1'b1, i == 0, 1'b1);
            if (i == 1 || i == 4) begin
                step(1'($urandom), 1'b0, 1'($urandom), 1'b1);
                checks++;
                if (busy !== 1'b1 || dvld !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_busy got busy=%b dvld=%b want busy=1 dvld=0", busy, dvld);
                end
            end
        end
`ifdef HC_DESER_PARITY_EN
        step(^w, 1'b1, 1'b0, 1'b1);
`endif
        checks++;
        if (obs() !== {1'b1, 8'h3C, 3'b000} || obs() !== exp_outs()) begin
            errors++;
            $display("FAIL gap_word got %h want %h", obs(), {1'b1, 8'h3C, 3'b000});
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_overflow();
        apply_reset();
        send_word(8'h11, 1'b1, 1'b0, 1'b0);
        send_word(8'h22, 1'b1, 1'b0, 1'b0);
        send_word(8'h33, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs() !== {1'b1, 8'h11, 3'b010} || obs() !== exp_outs()) begin
            errors++;
            $display("FAIL ovf_full got %h want %h", obs(), {1'b1, 8'h11, 3'b010});
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs() !== {1'b1, 8'h22, 3'b010}) begin
            errors++;
            $display("FAIL ovf_pop1 got %h want %h", obs(), {1'b1, 8'h22, 3'b010});
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs() !== {1'b0, 8'h00, 3'b010} || obs() !== exp_outs()) begin
            errors++;
            $display("FAIL ovf_pop2 got %h want %h", obs(), {1'b0, 8'h00, 3'b010});
        end
    endtask

    task automatic test_resync();
        apply_reset();
        for (int i = 0; i < 5; i++) step(1'($urandom), 1'b1, 1'b0, 1'b1);
        send_word(8'hF0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (obs() !== {1'b1, 8'hF0, 3'b000} || obs() !== exp_outs()) begin
            errors++;
            $display("FAIL resync_word got %h want %h", obs(), {1'b1, 8'hF0, 3'b000});
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (dvld !== 1'b0) begin
            errors++;
            $display("FAIL resync_single got dvld=%b want 0", dvld);
        end
        // Full FIFO with pop on the push edge: accepted, no overflow.
        apply_reset();
        send_word(8'h5A, 1'b1, 1'b0, 1'b0);
        send_word(8'h69, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'($urandom), 1'b1, 1'b0, 1'b0);
        send_word(8'hF0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (obs() !== {1'b1, 8'h69, 3'b000} || obs() !== exp_outs()) begin
            errors++;
            $display("FAIL resync_full got %h want %h", obs(), {1'b1, 8'h69, 3'b000});
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs() !== {1'b1, 8'hF0, 3'b000}) begin
            errors++;
            $display("FAIL resync_full_pop got %h want %h", obs(), {1'b1, 8'hF0, 3'b000});
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        send_word(8'hC3, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'($urandom), 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs() !== exp_outs() || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre got %h want %h", obs(), exp_outs());
        end
        #2 rb = 1'b0;
        #1;
        checks++;
        if (obs() !== '0) begin
            errors++;
            $display("FAIL mid_async got %h want %h", obs(), {OW{1'b0}});
        end
        @(negedge clk);
        rb = 1'b1;
        model_clear();
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

`ifdef HC_DESER_PARITY_EN
    task automatic test_parity();
        logic [W-1:0] w;
        apply_reset();
        w = 8'h07;
        for (int i = 0; i < W; i++) step(w[i], 1'b1, i == 0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs() !== {1'b1, 8'h07, 3'b000} || obs() !== exp_outs()) begin
            errors++;
            $display("FAIL par_good got %h want %h", obs(), {1'b1, 8'h07, 3'b000});
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < W; i++) step(w[i], 1'b1, i == 0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs() !== {1'b1, 8'h07, 3'b100} || obs() !== exp_outs()) begin
            errors++;
            $display("FAIL par_bad got %h want %h", obs(), {1'b1, 8'h07, 3'b100});
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < W; i++) step(w[i], 1'b1, i == 0, 1'b0);
        checks++;
        if (busy !== 1'b1 || dvld !== 1'b0) begin
            errors++;
            $display("FAIL par_wait got busy=%b dvld=%b want busy=1 dvld=0", busy, dvld);
        end
        apply_reset();
        checks++;
        if (obs() !== '0) begin
            errors++;
            $display("FAIL par_reset got %h want %h", obs(), {OW{1'b0}});
        end
    endtask
`endif

    task automatic test_random();
        int      vp;
        int      rp;
        logic    v;
        apply_reset();
        for (int n = 0; n < 4000; n++) begin
            // Shift sval/drdy density every 500 cycles to hit both full and idle FIFO.
            vp = 40 + 15 * ((n / 500) % 4);
            rp = 10 + 25 * ((n / 500) % 4);
            v  = ($urandom_range(99) < vp);
            if ($urandom_range(999) == 0) begin
                apply_reset();
            end else begin
                step(1'($urandom), v, $urandom_range(29) == 0, $urandom_range(99) < rp);
            end
            checks++;
            if (obs() !== exp_outs()) begin
                errors++;
                $display("FAIL random n=%0d got %h want %h", n, obs(), exp_outs());
            end
        end
    endtask

    initial begin
        rb   = 1'b0;
        sin  = 1'b0;
        sval = 1'b0;
        ssof = 1'b0;
        drdy = 1'b0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_gapped();
        test_overflow();
        test_resync();
        test_reset_mid();
`ifdef HC_DESER_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hc_deser_rx.md
Name: hc_deser_rx

Overview:
- Serial receiver for a falling-edge transmitter. Upstream launches `sin`/`sval`/`ssof` on the falling edge of `clk`; this block captures them on the rising edge, so every input path is a deliberate half-cycle (neg->pos) timing path.
- Deserializes LSB-first bits into WIDTH-bit words.
- Presents words on a valid/ready interface through a 2-entry output FIFO.
- Used as an STA exercise block and as a functional counterpart to the half-cycle transmit circuits.

Parameters:
- WIDTH, 8, data bits per word (legal range 2..32).

Ports:
- clk  input  1  clock; all internal flops on rising edge.
- rb  input  1  asynchronous active-low reset.
- sin  input  1  serial data bit, launched upstream on falling edge.
- sval  input  1  `sin` is a valid bit this cycle.
- ssof  input  1  start-of-frame; qualifies the bit carried with `sval`=1 as bit 0.
- dout  output  WIDTH  FIFO head word.
- dvld  output  1  FIFO non-empty (`dout` valid).
- drdy  input  1  consumer ready; pop when `dvld` && `drdy`.
- perr  output  1  parity error flag of FIFO head entry.
- ovf  output  1  sticky overflow flag.
- busy  output  1  partial word in progress (bit count != 0).

Behaviour:
- Reset (rb=0, asynchronous):
  - `dout`=0, `dvld`=0, `perr`=0, `ovf`=0, `busy`=0.
  - Bit counter=0, shift register=0, FIFO empty, FSM=SHIFT.
- Bit capture: only rising edges with `sval`=1 count. Gaps with `sval`=0 hold all state.
- FSM states: SHIFT (collecting data bits), PAR (awaiting parity bit; reachable only with PARITY_EN).
- SHIFT, bit accepted:
  - `sin` enters the shift register MSB-side (LSB-first word assembly).
  - Counter increments.
  - On bit WIDTH-1 without PARITY_EN: the word {sin, shreg[WIDTH-1:1]} is pushed into the FIFO on that same edge, counter returns to 0, and `dvld` is high after that edge (0-cycle latency from last capture).
  - On bit WIDTH-1 with PARITY_EN: go to PAR.
- PAR, bit accepted: push word plus parity result, return to SHIFT, counter=0.
- `ssof`=1 with `sval`=1: discards any partial word (including one waiting in PAR), and `sin` becomes bit 0. `ssof` with `sval`=0 is ignored. No frame sync is required: bits without `ssof` continue the current count.
- FIFO: 2 entries, in-order.
  - `dout`/`perr` show the head entry; `dout` is 0 when the FIFO is empty.
  - Pop happens on an edge with `dvld` && `drdy`.
- Push when full:
  - Without a simultaneous pop: the word is dropped, FIFO contents are unchanged, and `ovf` is set and held until reset.
  - With a simultaneous pop (full and `drdy`=1): the push is accepted and there is no overflow.
- `busy` = (counter != 0) || (FSM == PAR).
- Reset mid-word or mid-FIFO: everything is cleared; partial and stored words are lost.

Optional Feature:
- Macro HC_DESER_PARITY_EN.
- Defined:
  - Each word is followed by one even-parity bit, so the XOR of the WIDTH data bits and the parity bit must be 0.
  - The FSM uses PAR.
  - A mismatch stores perr=1 with that word.
  - The word is still delivered.
- Undefined: no PAR state, `perr` tied 0, words complete after WIDTH bits.

Test Plan:
- Reset: hold rb=0 with random `sin`/`sval` -> dout=0, dvld=0, perr=0, ovf=0, busy=0. Release rb -> outputs unchanged until bits arrive.
- Back-to-back word: WIDTH=8, drdy=1, bits of 0xA5 LSB-first with sval=1 on 8 consecutive cycles and ssof on the first -> after the 8th capture edge dvld=1, dout=0xA5 for exactly 1 cycle, busy falls to 0.
- Gapped input: send 0x3C with sval=0 cycles inserted after bits 2 and 5 -> single word 0x3C; busy=1 throughout the gaps.
- Overflow: drdy=0, send 0x11, 0x22, 0x33 -> FIFO holds 0x11, 0x22 and ovf=1. Then drdy=1 -> pops 0x11 then 0x22, 0x33 never appears, ovf stays 1.
- Resync: send 5 bits of garbage, then ssof plus 8 bits of 0xF0 -> only 0xF0 is delivered. Repeat with the FIFO full and drdy=1 at the push edge -> word accepted, ovf=0.
- Parity (HC_DESER_PARITY_EN): 0x07 followed by parity bit 1 -> dout=0x07, perr=0. 0x07 followed by parity bit 0 -> dout=0x07, perr=1. Reset asserted in PAR -> busy=0, FIFO empty.
